// File: rtl/apb_defs.sv
// Shared APB arbiter definitions: state encodings, width defaults, requester limit.
// Width defaults come from ADDR_WIDTH / DATA_WIDTH macros when not set externally.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package apb_defs;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd1,
        ST_SETUP  = 2'd3,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam int ADDR_WIDTH_DEF = `ADDR_WIDTH;
    localparam int DATA_WIDTH_DEF = `DATA_WIDTH;
    localparam int N_REQ_MAX      = 8;
endpackage

// File: rtl/apb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap-around.
module apb_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    localparam int PW = IDX_W + 1;

    logic [PW-1:0] pos;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // ptr and k are both below N_REQ, so one subtraction folds the sum back in range
            pos = {1'b0, ptr} + PW'(k);
            if (pos >= PW'(N_REQ))
                pos = pos - PW'(N_REQ);
            if (!any && req[pos[IDX_W-1:0]]) begin
                any = 1'b1;
                idx = pos[IDX_W-1:0];
                gnt[pos[IDX_W-1:0]] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/apb_arbiter.sv
// Round-robin arbiter sharing one APB bus between N_REQ requesters.
// Define APB3_EN to add pready/pslverr (wait states and slave error reporting).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module apb_arbiter
    import apb_defs::*;
#(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = `ADDR_WIDTH,
    parameter int DATA_W = `DATA_WIDTH
) (
    input  logic                    pclk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_write,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    rsp_err,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [ADDR_W-1:0]       paddr,
    output logic [DATA_W-1:0]       pwdata,
    input  logic [DATA_W-1:0]       prdata
`ifdef APB3_EN
    ,
    input  logic                    pready,
    input  logic                    pslverr
`endif
);
    localparam int IDX_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > N_REQ_MAX) begin : g_bad_n_req
        $error("apb_arbiter: N_REQ out of range");
    end

    apb_state_e state, state_nxt;

    logic [IDX_W-1:0] ptr, gnt_idx, pick_idx;
    logic [N_REQ-1:0] pick_gnt;
    logic             pick_any;
    logic             done, err_in, complete, accept;

    logic [N_REQ-1:0][ADDR_W-1:0] addr_a;
    logic [N_REQ-1:0][DATA_W-1:0] wdata_a;

    assign addr_a  = req_addr;
    assign wdata_a = req_wdata;

    apb_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req (req_valid),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

`ifdef APB3_EN
    assign done   = pready;
    assign err_in = pslverr;
`else
    assign done   = 1'b1;
    assign err_in = 1'b0;
`endif

    assign complete = (state == ST_ACCESS) && done;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    accept    = 1'b1;
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (done) begin
                    accept    = pick_any;
                    state_nxt = pick_any ? ST_SETUP : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // No accept pulse while reset is asserted; the requester must see its request still pending.
        if (rst)
            accept = 1'b0;
    end

    assign req_ready = accept ? pick_gnt : '0;
    assign psel      = (state == ST_SETUP) || (state == ST_ACCESS);
    assign penable   = (state == ST_ACCESS);

    always_ff @(posedge pclk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            gnt_idx   <= '0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            rsp_valid <= '0;
            if (complete) begin
                rsp_valid[gnt_idx] <= 1'b1;
                rsp_rdata          <= prdata;
                rsp_err            <= err_in;
            end
            if (accept) begin
                paddr   <= addr_a[pick_idx];
                pwrite  <= req_write[pick_idx];
                pwdata  <= wdata_a[pick_idx];
                gnt_idx <= pick_idx;
                ptr     <= (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_apb_arbiter.sv
// Self-checking bench for apb_arbiter: directed scenarios plus random traffic, checked
// every cycle against a transfer-level model of the arbitration and APB phase rules.
module tb_apb_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            pclk = 1'b0;
    logic            rst  = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_write = '0;
    logic [N*AW-1:0] req_addr  = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    req_ready, rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err, psel, penable, pwrite;
    logic [AW-1:0]   paddr;
    logic [DW-1:0]   pwdata;
    logic [DW-1:0]   prdata = '0;
`ifdef APB3_EN
    logic            pready  = 1'b1;
    logic            pslverr = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 pclk = ~pclk;

    apb_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .pclk      (pclk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata)
`ifdef APB3_EN
        ,
        .pready    (pready),
        .pslverr   (pslverr)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: one transfer owns the bus from its accept cycle until completion.
    bit          m_busy = 1'b0;
    int          m_cyc  = 0;     // cycles since the current transfer was accepted
    int          m_ptr  = 0;
    int          m_idx  = 0;
    logic [AW-1:0] m_addr  = '0;
    logic          m_write = 1'b0;
    logic [DW-1:0] m_wdata = '0;
    logic [N-1:0]  m_rsp   = '0;
    logic [DW-1:0] m_rdata = '0;
    logic          m_err   = 1'b0;
    logic [N-1:0]  m_gnt   = '0;
    int            gnt_log[$];

    task automatic eval();
        logic pr, er, cmpl;
        int win;
        logic [N-1:0] exp_rdy;
`ifdef APB3_EN
        pr = pready;
        er = pslverr;
`else
        pr = 1'b1;
        er = 1'b0;
`endif
        chk("psel", psel, 64'(m_busy && m_cyc >= 1));
        chk("penable", penable, 64'(m_busy && m_cyc >= 2));
        if (m_busy) begin
            chk("paddr", paddr, 64'(m_addr));
            chk("pwrite", pwrite, 64'(m_write));
            chk("pwdata", pwdata, 64'(m_wdata));
        end
        chk("rsp_valid", rsp_valid, 64'(m_rsp));
        if (m_rsp != '0) begin
            chk("rsp_rdata", rsp_rdata, 64'(m_rdata));
            chk("rsp_err", rsp_err, 64'(m_err));
        end

        cmpl = m_busy && m_cyc >= 2 && pr;
        win  = -1;
        if (!rst && (!m_busy || cmpl)) begin
            for (int k = 0; k < N; k++) begin
                int j = (m_ptr + k) % N;
                if (win < 0 && req_valid[j]) win = j;
            end
        end
        exp_rdy = (win >= 0) ? (N'(1) << win) : '0;
        chk("req_ready", req_ready, 64'(exp_rdy));

        if (rst) begin
            m_busy = 1'b0; m_cyc = 0; m_ptr = 0; m_rsp = '0; m_gnt = '0;
        end else begin
            m_rsp = cmpl ? (N'(1) << m_idx) : '0;
            if (cmpl) begin
                m_rdata = prdata;
                m_err   = er;
                m_busy  = 1'b0;
            end
            if (m_busy) m_cyc++;
            if (win >= 0) begin
                m_busy  = 1'b1;
                m_cyc   = 1;
                m_idx   = win;
                m_addr  = req_addr[win*AW +: AW];
                m_write = req_write[win];
                m_wdata = req_wdata[win*DW +: DW];
                m_ptr   = (win + 1) % N;
                gnt_log.push_back(win);
            end
            m_gnt = exp_rdy;
        end
    endtask

    task automatic tick();
        @(negedge pclk);
        eval();
        @(posedge pclk);
        #1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]          = 1'b1;
        req_write[i]          = wr;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int cnt;

        // Reset state, sampled after the first reset edge
        @(negedge pclk);
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_req_ready", req_ready, 0);
        @(posedge pclk); #1;
        do_reset();

        // Single read from requester 2
        gnt_log.delete();
        set_req(2, 1'b0, 32'h10, 32'h0);
        prdata = 32'hA5A5A5A5;
        tick();
        req_valid &= ~m_gnt;
        for (int c = 0; c < 4; c++) tick();
        chk("rd_gnt", gnt_log.size() == 1 ? gnt_log[0] : -1, 2);

        // All four write persistently from reset: grants 0,1,2,3,0
        do_reset();
        gnt_log.delete();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, $urandom, $urandom);
        for (int c = 0; c < 10; c++) begin
            tick();
            for (int i = 0; i < N; i++)
                if (m_gnt[i]) set_req(i, 1'b1, $urandom, $urandom);
        end
        req_valid = '0;
        for (int c = 0; c < 4; c++) tick();
        chk("rr_cnt", gnt_log.size() >= 5, 1);
        for (int g = 0; g < 5 && g < gnt_log.size(); g++)
            chk($sformatf("rr_order%0d", g), gnt_log[g], g % N);

        // Pointer wrap: after grant to 3, with 0 and 3 pending, 0 goes first
        do_reset();
        set_req(3, 1'b0, 32'h30, 32'h0);
        tick();
        gnt_log.delete();
        set_req(3, 1'b1, 32'h34, 32'h3333);
        set_req(0, 1'b1, 32'h04, 32'h0000);
        for (int c = 0; c < 6; c++) begin
            tick();
            req_valid &= ~m_gnt;
        end
        chk("wrap_first", gnt_log.size() > 0 ? gnt_log[0] : -1, 0);
        chk("wrap_second", gnt_log.size() > 1 ? gnt_log[1] : -1, 3);

`ifdef APB3_EN
        // Wait states with slave error on completion
        do_reset();
        set_req(1, 1'b1, 32'h44, 32'hBEEF);
        tick();
        req_valid &= ~m_gnt;
        tick();                     // SETUP
        pready = 1'b0;
        cnt = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            cnt += int'(penable);
        end
        pready = 1'b1; pslverr = 1'b1;
        tick();
        pslverr = 1'b0;
        @(negedge pclk);
        chk("ws_access_cycles", cnt, 3);
        chk("ws_rsp_err", {rsp_valid[1], rsp_err}, 2'b11);
        @(posedge pclk); #1;
        tick();
`endif

        // Reset during ACCESS: transfer abandoned, no response, pointer back to 0
        do_reset();
        set_req(2, 1'b1, 32'h20, 32'h2);
        tick();
        req_valid &= ~m_gnt;
        tick();                     // SETUP
        rst = 1'b1;
        tick();                     // ACCESS with reset
        rst = 1'b0;
        @(negedge pclk);
        chk("rstacc_psel", psel, 0);
        chk("rstacc_penable", penable, 0);
        chk("rstacc_rsp", rsp_valid, 0);
        @(posedge pclk); #1;
        gnt_log.delete();
        set_req(1, 1'b0, 32'h11, 32'h0);
        set_req(3, 1'b0, 32'h33, 32'h0);
        tick();
        req_valid &= ~m_gnt;
        chk("rstacc_gnt", gnt_log.size() > 0 ? gnt_log[0] : -1, 1);
        for (int c = 0; c < 6; c++) begin
            tick();
            req_valid &= ~m_gnt;
        end

        // Requester 1 withdraws while requester 0 is in ACCESS
        do_reset();
        gnt_log.delete();
        set_req(0, 1'b1, 32'h100, 32'h1);
        tick();
        req_valid &= ~m_gnt;
        set_req(1, 1'b0, 32'h200, 32'h0);
        tick();                     // SETUP, requester 1 raised
        req_valid[1] = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        cnt = 0;
        foreach (gnt_log[g]) if (gnt_log[g] == 1) cnt++;
        chk("drop_no_gnt", cnt, 0);
        @(negedge pclk);
        chk("drop_idle", psel, 0);
        @(posedge pclk); #1;

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (m_gnt[i] || !req_valid[i]) begin
                    if ($urandom_range(99) < 40) set_req(i, 1'($urandom), $urandom, $urandom);
                    else req_valid[i] = 1'b0;
                end else if ($urandom_range(99) < 5) begin
                    req_valid[i] = 1'b0;
                end
            end
            prdata = $urandom;
            rst    = ($urandom_range(99) < 2);
`ifdef APB3_EN
            pready  = ($urandom_range(99) < 60);
            pslverr = 1'($urandom);
`endif
        end
        rst = 1'b0;
        req_valid = '0;
        for (int c = 0; c < 3; c++) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
